// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and memory loads into the register file write port,
// with load alignment/extension, a retired-instruction counter and sticky error flags.
module wb_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_res,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd,
    output logic [31:0] reg_wr_dat,
    output logic        regWrite,
    output logic [31:0] retire_cnt,
    output logic        err_misaligned,
    output logic        err_timeout
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e          state;
    logic [CntW-1:0] wait_cnt;
    logic [4:0]      ld_rd;
    logic            ld_wen;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_off;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
    logic            ld_ok;

    assign in_ready = (state == StIdle);

    // Extract and extend the addressed data from the response word.
    always_comb begin
        ld_byte = 8'h00;
        unique case (ld_off)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = 32'h0;
        ld_ok   = 1'b0;
        case (ld_funct3)
            3'b000: begin
                ld_data = {{24{ld_byte[7]}}, ld_byte};
                ld_ok   = 1'b1;
            end
            3'b100: begin
                ld_data = {24'h0, ld_byte};
                ld_ok   = 1'b1;
            end
            3'b001: begin
                ld_data = {{16{ld_half[15]}}, ld_half};
                ld_ok   = ~ld_off[0];
            end
            3'b101: begin
                ld_data = {16'h0, ld_half};
                ld_ok   = ~ld_off[0];
            end
            3'b010: begin
                ld_data = mem_rdata;
                ld_ok   = (ld_off == 2'b00);
            end
            default: begin
                ld_data = 32'h0;
                ld_ok   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= StIdle;
            wait_cnt       <= '0;
            ld_rd          <= 5'd0;
            ld_wen         <= 1'b0;
            ld_funct3      <= 3'd0;
            ld_off         <= 2'd0;
            rd             <= 5'd0;
            reg_wr_dat     <= 32'h0;
            regWrite       <= 1'b0;
            retire_cnt     <= 32'h0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            regWrite <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        if (in_is_load) begin
                            ld_rd     <= in_rd;
                            ld_wen    <= in_wen;
                            ld_funct3 <= in_funct3;
                            ld_off    <= in_alu_res[1:0];
                            wait_cnt  <= '0;
                            state     <= StLoadWait;
                        end else begin
                            regWrite   <= in_wen && (in_rd != 5'd0);
                            rd         <= in_rd;
                            reg_wr_dat <= in_alu_res;
                            retire_cnt <= retire_cnt + 32'd1;
                        end
                    end
                end
                StLoadWait: begin
                    // A response arriving on the last wait cycle takes priority over timeout.
                    if (mem_rsp_valid) begin
                        if (ld_ok) begin
                            regWrite   <= ld_wen && (ld_rd != 5'd0);
                            rd         <= ld_rd;
                            reg_wr_dat <= ld_data;
                            retire_cnt <= retire_cnt + 32'd1;
                        end else begin
                            err_misaligned <= 1'b1;
                        end
                        state <= StIdle;
                    end else if (wait_cnt == WaitLast) begin
                        err_timeout <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a short memory timeout.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic        in_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_alu_res = 32'h0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [4:0]  rd;
    logic [31:0] reg_wr_dat;
    logic        regWrite;
    logic [31:0] retire_cnt;
    logic        err_misaligned;
    logic        err_timeout;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_retire = 32'h0;

    wb_stage #(.MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_wen         (in_wen),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_alu_res     (in_alu_res),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rdata      (mem_rdata),
        .rd             (rd),
        .reg_wr_dat     (reg_wr_dat),
        .regWrite       (regWrite),
        .retire_cnt     (retire_cnt),
        .err_misaligned (err_misaligned),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic is_load, input logic [4:0] r, input logic [2:0] f3,
                             input logic [31:0] res);
        in_valid   = 1'b1;
        in_is_load = is_load;
        in_rd      = r;
        in_wen     = 1'b1;
        in_funct3  = f3;
        in_alu_res = res;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #23;
        n_checks++;
        if ({regWrite, rd, reg_wr_dat} !== 38'h0) begin
            n_errors++;
            $display("FAIL reset_wrport: got %b/%0d/%h want 0/0/0", regWrite, rd, reg_wr_dat);
        end
        n_checks++;
        if ({retire_cnt, err_misaligned, err_timeout, in_ready} !== 35'h1) begin
            n_errors++;
            $display("FAIL reset_state: got cnt=%h mis=%b to=%b rdy=%b want 0/0/0/1",
                     retire_cnt, err_misaligned, err_timeout, in_ready);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds [3] = '{5'd5, 5'd6, 5'd7};
        logic [31:0] dats [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b0, rds[i], 3'd0, dats[i]);
            step();
            exp_retire++;
            n_checks++;
            if (regWrite !== 1'b1 || rd !== rds[i] || reg_wr_dat !== dats[i] || in_ready !== 1'b1)
            begin
                n_errors++;
                $display("FAIL b2b_%0d: got we=%b rd=%0d d=%h rdy=%b want 1/%0d/%h/1",
                         i, regWrite, rd, reg_wr_dat, in_ready, rds[i], dats[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (regWrite !== 1'b0 || retire_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL b2b_end: got we=%b cnt=%0d want 0/3", regWrite, retire_cnt);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  offs [6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [6] = '{32'h0000007F, 32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF,
                                  32'h00007F01, 32'h80FF7F01};
        for (int i = 0; i < 6; i++) begin
            set_instr(1'b1, 5'd10, f3s[i], {30'h400, offs[i]});
            step();
            in_valid = 1'b0;
            n_checks++;
            if (in_ready !== 1'b0 || regWrite !== 1'b0) begin
                n_errors++;
                $display("FAIL load_%0d_wait: got rdy=%b we=%b want 0/0", i, in_ready, regWrite);
            end
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'h80FF7F01;
            step();
            mem_rsp_valid = 1'b0;
            exp_retire++;
            n_checks++;
            if (regWrite !== 1'b1 || rd !== 5'd10 || reg_wr_dat !== exps[i] ||
                in_ready !== 1'b1 || retire_cnt !== exp_retire) begin
                n_errors++;
                $display("FAIL load_%0d: got we=%b rd=%0d d=%h rdy=%b cnt=%0d want 1/10/%h/1/%0d",
                         i, regWrite, rd, reg_wr_dat, in_ready, retire_cnt, exps[i], exp_retire);
            end
        end
    endtask

    task automatic test_delay();
        set_instr(1'b1, 5'd12, 3'b010, 32'h2000);
        step();
        // Non-load held valid while the load is still outstanding.
        set_instr(1'b0, 5'd13, 3'd0, 32'h55);
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (in_ready !== 1'b0 || regWrite !== 1'b0 || retire_cnt !== exp_retire) begin
                n_errors++;
                $display("FAIL delay_wait_%0d: got rdy=%b we=%b cnt=%0d want 0/0/%0d",
                         i, in_ready, regWrite, retire_cnt, exp_retire);
            end
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEADBEEF;
        step();
        mem_rsp_valid = 1'b0;
        exp_retire++;
        n_checks++;
        if (regWrite !== 1'b1 || rd !== 5'd12 || reg_wr_dat !== 32'hDEADBEEF ||
            in_ready !== 1'b1 || retire_cnt !== exp_retire) begin
            n_errors++;
            $display("FAIL delay_rsp: got we=%b rd=%0d d=%h rdy=%b cnt=%0d want 1/12/deadbeef/1/%0d",
                     regWrite, rd, reg_wr_dat, in_ready, retire_cnt, exp_retire);
        end
        step();
        in_valid = 1'b0;
        exp_retire++;
        n_checks++;
        if (regWrite !== 1'b1 || rd !== 5'd13 || reg_wr_dat !== 32'h55 ||
            retire_cnt !== exp_retire) begin
            n_errors++;
            $display("FAIL delay_held: got we=%b rd=%0d d=%h cnt=%0d want 1/13/55/%0d",
                     regWrite, rd, reg_wr_dat, retire_cnt, exp_retire);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0] f3s  [2] = '{3'b010, 3'b011};
        logic [1:0] offs [2] = '{2'd2, 2'd0};
        for (int i = 0; i < 2; i++) begin
            set_instr(1'b1, 5'd9, f3s[i], {30'h10, offs[i]});
            step();
            in_valid      = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'h12345678;
            step();
            mem_rsp_valid = 1'b0;
            n_checks++;
            if (regWrite !== 1'b0 || err_misaligned !== 1'b1 || retire_cnt !== exp_retire ||
                in_ready !== 1'b1 || err_timeout !== 1'b0) begin
                n_errors++;
                $display("FAIL misalign_%0d: got we=%b mis=%b cnt=%0d rdy=%b to=%b want 0/1/%0d/1/0",
                         i, regWrite, err_misaligned, retire_cnt, in_ready, err_timeout, exp_retire);
            end
        end
    endtask

    task automatic test_timeout();
        set_instr(1'b1, 5'd3, 3'b010, 32'h3000);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (err_timeout !== (k == 4) || in_ready !== (k == 4) || regWrite !== 1'b0 ||
                retire_cnt !== exp_retire) begin
                n_errors++;
                $display("FAIL timeout_cyc%0d: got to=%b rdy=%b we=%b cnt=%0d want %b/%b/0/%0d",
                         k + 1, err_timeout, in_ready, regWrite, retire_cnt,
                         (k == 4), (k == 4), exp_retire);
            end
        end
        // Fresh run: response on the last wait cycle must win over the timeout.
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        exp_retire = 32'h0;
        step();
        set_instr(1'b1, 5'd4, 3'b010, 32'h3000);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFEF00D;
        step();
        mem_rsp_valid = 1'b0;
        exp_retire++;
        n_checks++;
        if (regWrite !== 1'b1 || rd !== 5'd4 || reg_wr_dat !== 32'hCAFEF00D ||
            err_timeout !== 1'b0 || retire_cnt !== exp_retire || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_late_rsp: got we=%b rd=%0d d=%h to=%b cnt=%0d rdy=%b want 1/4/cafef00d/0/%0d/1",
                     regWrite, rd, reg_wr_dat, err_timeout, retire_cnt, in_ready, exp_retire);
        end
    endtask

    task automatic test_x0();
        set_instr(1'b0, 5'd0, 3'd0, 32'hABCD);
        step();
        in_valid = 1'b0;
        exp_retire++;
        n_checks++;
        if (regWrite !== 1'b0 || retire_cnt !== exp_retire) begin
            n_errors++;
            $display("FAIL x0_write: got we=%b cnt=%0d want 0/%0d", regWrite, retire_cnt, exp_retire);
        end
    endtask

    task automatic test_reset_mid_load();
        // Leave a nonzero write port so the reset has something to clear.
        set_instr(1'b0, 5'd8, 3'd0, 32'h77);
        step();
        set_instr(1'b1, 5'd8, 3'b010, 32'h4000);
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_pre: got rdy=%b want 0", in_ready);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({regWrite, rd, reg_wr_dat, retire_cnt, err_misaligned, err_timeout} !== 72'h0 ||
            in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid: got we=%b rd=%0d d=%h cnt=%0d mis=%b to=%b rdy=%b want all 0, rdy 1",
                     regWrite, rd, reg_wr_dat, retire_cnt, err_misaligned, err_timeout, in_ready);
        end
        #1 reset = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h99999999;
        step();
        mem_rsp_valid = 1'b0;
        step();
        n_checks++;
        if (regWrite !== 1'b0 || retire_cnt !== 32'h0 || reg_wr_dat !== 32'h0 ||
            in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_late_rsp: got we=%b cnt=%0d d=%h rdy=%b want 0/0/0/1",
                     regWrite, retire_cnt, reg_wr_dat, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_delay();
        test_misaligned();
        test_x0();
        test_timeout();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
